// File: rtl/det_event_monitor.sv
// det_event_monitor
//   Counts match pulses from the 11011 sequence detector over back-to-back
//   windows of WINDOW clock cycles. Each closed window's count is offered
//   on a valid/ready report interface. A threshold alarm is raised when
//   that count reaches THRESH.
//
//   Optional build macro: DET_MON_GAP_EN. When it is defined, the module
//   also reports the minimum gap between consecutive pulses in each window.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   enable       1 = run windows, 0 = idle (the partial window is discarded)
//   det_pulse    one event per high cycle
//   rpt_ready    consumer accepts the report when rpt_valid is also high
//   rpt_valid    a report is pending
//   rpt_count    event count of the reported window (saturating)
//   rpt_overrun  the pending report overwrote an unaccepted earlier report
//   alarm        the last closed window had count >= THRESH
//   running      the FSM is in RUN
//   rpt_min_gap  (DET_MON_GAP_EN only) minimum pulse distance in the
//                reported window; all-ones if the window had < 2 pulses
module det_event_monitor #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned WIN_W  = 16,
  parameter int unsigned WINDOW = 1000,
  parameter int unsigned THRESH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             det_pulse,
  input  logic             rpt_ready,
  output logic             rpt_valid,
  output logic [CNT_W-1:0] rpt_count,
  output logic             rpt_overrun,
  output logic             alarm,
  output logic             running
`ifdef DET_MON_GAP_EN
  ,
  output logic [WIN_W-1:0] rpt_min_gap
`endif
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;

  localparam logic [WIN_W-1:0] LAST = WIN_W'(WINDOW - 1);

  logic             state;
  logic [WIN_W-1:0] timer;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_inc;
  logic             win_close;
  logic             accept;
  logic             hit;
  logic             drop;

  always_comb begin
    acc_inc   = (det_pulse && (acc != '1)) ? acc + 1'b1 : acc;
    win_close = (state == S_RUN) && (timer == LAST);
    accept    = rpt_valid && rpt_ready;
    hit       = (32'(acc_inc) >= THRESH);
    drop      = (state == S_RUN) && !enable;
  end

  assign running = (state == S_RUN);

  // Window timer, accumulator and FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      timer <= '0;
      acc   <= '0;
    end else if (state == S_IDLE) begin
      timer <= '0;
      acc   <= '0;
      if (enable) state <= S_RUN;
    end else begin
      if (win_close || !enable) begin
        timer <= '0;
        acc   <= '0;
      end else begin
        timer <= timer + 1'b1;
        acc   <= acc_inc;
      end
      if (!enable) state <= S_IDLE;
    end
  end

  // Report register. A close takes priority over an accept in the same
  // cycle, and it also completes when enable falls in the close cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_valid   <= 1'b0;
      rpt_count   <= '0;
      rpt_overrun <= 1'b0;
      alarm       <= 1'b0;
    end else if (win_close) begin
      rpt_valid   <= 1'b1;
      rpt_count   <= acc_inc;
      rpt_overrun <= rpt_valid && !rpt_ready;
      alarm       <= hit;
    end else begin
      if (accept) begin
        rpt_valid   <= 1'b0;
        rpt_overrun <= 1'b0;
      end
      if (drop) alarm <= 1'b0;
    end
  end

`ifdef DET_MON_GAP_EN
  // gap_cnt is the distance from the last pulse in this window to the
  // current cycle. It is only meaningful once gap_seen is set.
  logic [WIN_W-1:0] gap_cnt;
  logic             gap_seen;
  logic [WIN_W-1:0] gap_min;
  logic [WIN_W-1:0] gap_min_nxt;

  always_comb begin
    gap_min_nxt = gap_min;
    if (det_pulse && gap_seen && (gap_cnt < gap_min)) gap_min_nxt = gap_cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt  <= '0;
      gap_seen <= 1'b0;
      gap_min  <= '1;
    end else if ((state != S_RUN) || win_close || !enable) begin
      gap_cnt  <= '0;
      gap_seen <= 1'b0;
      gap_min  <= '1;
    end else begin
      if (det_pulse) begin
        gap_seen <= 1'b1;
        gap_cnt  <= WIN_W'(1);
      end else if (gap_seen && (gap_cnt != '1)) begin
        gap_cnt  <= gap_cnt + 1'b1;
      end
      gap_min <= gap_min_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          rpt_min_gap <= '1;
    else if (win_close) rpt_min_gap <= gap_min_nxt;
  end
`endif

endmodule

// File: tb/tb_det_event_monitor.sv
module tb_det_event_monitor;

  logic clk = 1'b0;
  logic reset, enable, det_pulse, rpt_ready;

  logic       rpt_valid, rpt_overrun, alarm, running;
  logic [7:0] rpt_count;
  logic       s_valid, s_overrun, s_alarm, s_running;
  logic [2:0] s_count;
`ifdef DET_MON_GAP_EN
  logic [15:0] rpt_min_gap, s_min_gap;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  det_event_monitor #(.CNT_W(8), .WIN_W(16), .WINDOW(16), .THRESH(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .det_pulse(det_pulse),
    .rpt_ready(rpt_ready), .rpt_valid(rpt_valid), .rpt_count(rpt_count),
    .rpt_overrun(rpt_overrun), .alarm(alarm), .running(running)
`ifdef DET_MON_GAP_EN
    , .rpt_min_gap(rpt_min_gap)
`endif
  );

  det_event_monitor #(.CNT_W(3), .WIN_W(16), .WINDOW(16), .THRESH(4)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .det_pulse(det_pulse),
    .rpt_ready(rpt_ready), .rpt_valid(s_valid), .rpt_count(s_count),
    .rpt_overrun(s_overrun), .alarm(s_alarm), .running(s_running)
`ifdef DET_MON_GAP_EN
    , .rpt_min_gap(s_min_gap)
`endif
  );

  typedef struct {
    logic       en, p, r;
    logic       chk, cc;
    logic       ev;
    logic [7:0] ec;
    logic       eo, ea, er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic en, p, r, chk, cc, ev,
                              input logic [7:0] ec, input logic eo, ea, er);
    vec_t v;
    v.en = en; v.p = p; v.r = r; v.chk = chk; v.cc = cc;
    v.ev = ev; v.ec = ec; v.eo = eo; v.ea = ea; v.er = er;
    return v;
  endfunction

  // Inputs are applied at a falling edge; outputs are sampled at the next
  // falling edge, after one rising edge.
  task automatic cyc(input logic en, input logic p, input logic r);
    enable = en; det_pulse = p; rpt_ready = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_n(input int n, input logic en, input logic p, input logic r);
    for (int k = 0; k < n; k++) cyc(en, p, r);
  endtask

  task automatic chk(input string name, input logic ev, input logic [7:0] ec,
                     input logic cc, input logic eo, input logic ea, input logic er);
    n_tests++;
    if (rpt_valid !== ev || (cc && rpt_count !== ec) || rpt_overrun !== eo ||
        alarm !== ea || running !== er) begin
      n_fail++;
      $display("FAIL %s: got valid=%0b count=%0d overrun=%0b alarm=%0b running=%0b, want valid=%0b count=%0d%s overrun=%0b alarm=%0b running=%0b",
               name, rpt_valid, rpt_count, rpt_overrun, alarm, running,
               ev, ec, cc ? "" : "(any)", eo, ea, er);
    end
  endtask

  task automatic chk_sat(input string name, input logic ev, input logic [2:0] ec, input logic ea);
    n_tests++;
    if (s_valid !== ev || s_count !== ec || s_alarm !== ea) begin
      n_fail++;
      $display("FAIL %s: got valid=%0b count=%0d alarm=%0b, want valid=%0b count=%0d alarm=%0b",
               name, s_valid, s_count, s_alarm, ev, ec, ea);
    end
  endtask

`ifdef DET_MON_GAP_EN
  task automatic chk_gap(input string name, input logic [15:0] eg);
    n_tests++;
    if (rpt_min_gap !== eg) begin
      n_fail++;
      $display("FAIL %s: got min_gap=%0h, want %0h", name, rpt_min_gap, eg);
    end
  endtask
`endif

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; det_pulse = 1'b0; rpt_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; det_pulse = 1'b0; rpt_ready = 1'b0;
    @(negedge clk);
    chk("reset_state", 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef DET_MON_GAP_EN
    chk_gap("reset_gap", 16'hFFFF);
`endif
    reset = 1'b0;

    // Test 1: 3 pulses (cycles 1, 4, 9), ready=1 throughout.
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1));
    for (int k = 0; k < 16; k++)
      tbl.push_back(mk(1'b1, (k == 1 || k == 4 || k == 9), 1'b1,
                       (k == 7 || k == 15), 1'b1, (k == 15),
                       (k == 15) ? 8'd3 : 8'd0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].en, tbl[i].p, tbl[i].r);
      if (tbl[i].chk)
        chk($sformatf("t1_vec%0d", i), tbl[i].ev, tbl[i].ec, tbl[i].cc,
            tbl[i].eo, tbl[i].ea, tbl[i].er);
    end

    // Test 2: pulses straddling the window boundary are not merged.
    do_reset();
    cyc(1'b1, 1'b0, 1'b1);
    idle_n(15, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    chk("t2_win0", 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef DET_MON_GAP_EN
    chk_gap("t2_gap0", 16'hFFFF);
`endif
    cyc(1'b1, 1'b1, 1'b1);
    chk("t2_accept", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_n(15, 1'b1, 1'b0, 1'b1);
    chk("t2_win1", 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef DET_MON_GAP_EN
    chk_gap("t2_gap1", 16'hFFFF);
`endif

    // Test 3: overrun across two unaccepted closes.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) cyc(1'b1, (k < 5), 1'b0);
    chk("t3_win0", 1'b1, 8'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, (k < 2), 1'b0);
      if (k == 7) chk("t3_hold", 1'b1, 8'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    end
    chk("t3_overrun", 1'b1, 8'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("t3_accept", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Test 4: pulse held for a whole window; the 3-bit instance saturates.
    do_reset();
    cyc(1'b1, 1'b0, 1'b1);
    idle_n(16, 1'b1, 1'b1, 1'b1);
    chk_sat("t4_sat", 1'b1, 3'd7, 1'b1);
    chk("t4_full", 1'b1, 8'd16, 1'b1, 1'b0, 1'b1, 1'b1);

    // Test 5: enable dropped mid-window discards it and clears alarm.
    do_reset();
    cyc(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) cyc(1'b1, (k < 4), 1'b1);
    chk("t5_alarm_win", 1'b1, 8'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) cyc(1'b1, (k == 2 || k == 5), 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("t5_dropped", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_n(20, 1'b0, 1'b1, 1'b1);
    chk("t5_idle", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("t5_reenable", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) cyc(1'b1, (k == 3), 1'b1);
    chk("t5_fresh", 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1);

    // Test 6: min gap, then asynchronous reset with a report pending.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) cyc(1'b1, (k == 2 || k == 5 || k == 6), 1'b0);
    chk("t6_report", 1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef DET_MON_GAP_EN
    chk_gap("t6_gap", 16'h0001);
`endif
    idle_n(3, 1'b1, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_reset", 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef DET_MON_GAP_EN
    chk_gap("t6_reset_gap", 16'hFFFF);
`endif
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/det_event_monitor.md
Name: det_event_monitor

Overview:
- Downstream consumer of the 11011 sequence detector's registered one-cycle match pulse (dout -> det_pulse).
- Counts match pulses over fixed, back-to-back windows of WINDOW clock cycles.
- Presents each window's count to software/status logic through a valid/ready report interface.
- Raises a threshold alarm when a window's count reaches THRESH.

Parameters:
- CNT_W, 8, width of the event count and report counter; the count saturates at 2^CNT_W-1.
- WIN_W, 16, width of the window timer; WINDOW must not exceed 2^WIN_W.
- WINDOW, 1000, window length in clk cycles; must be at least 2.
- THRESH, 4, alarm threshold; alarm is set when the window count is greater than or equal to THRESH.

Ports:
- clk, input, 1, clock, rising edge.
- reset, input, 1, asynchronous active-high reset.
- enable, input, 1, high to run windows; low to idle.
- det_pulse, input, 1, match pulse from the detector; each high cycle is one event.
- rpt_ready, input, 1, consumer accepts the report when rpt_valid and rpt_ready are both high.
- rpt_valid, output, 1, a report is pending.
- rpt_count, output, CNT_W, event count for the reported window.
- rpt_overrun, output, 1, an unaccepted earlier report was overwritten by this one.
- alarm, output, 1, the last closed window had rpt_count >= THRESH.
- running, output, 1, FSM is in RUN.

Behaviour:
- Reset (asynchronous, active-high; clock clk):
  - rpt_valid=0, rpt_count=0, rpt_overrun=0, alarm=0, running=0.
  - FSM goes to IDLE; timer=0; acc=0.
- FSM states: IDLE and RUN.
- IDLE:
  - det_pulse is ignored; timer and acc are held at 0.
  - enable=1 -> RUN on the next edge; the first window starts in the first cycle in RUN (timer=0).
- RUN, every cycle:
  - acc increments when det_pulse=1, saturating at 2^CNT_W-1.
  - timer increments by 1.
- Window close:
  - Occurs in the cycle where timer==WINDOW-1; a pulse in that cycle is counted.
  - On that edge: rpt_count <= final acc, including that cycle's pulse.
  - rpt_valid <= 1; alarm <= (final acc >= THRESH).
  - timer <= 0 and acc <= 0, so the next window starts with no gap cycle.
  - Latency: rpt_valid is high in the cycle after the last window cycle.
- Report handshake:
  - rpt_count, rpt_overrun and rpt_valid are held stable while rpt_valid=1 and rpt_ready=0.
  - Accept (rpt_valid & rpt_ready) with no close in the same cycle -> rpt_valid <= 0 and rpt_overrun <= 0.
  - Close while a report is pending and not accepted that cycle -> new count overwrites the old one; rpt_overrun <= 1.
  - Close in the same cycle as an accept -> new report loads, rpt_valid stays 1, rpt_overrun <= 0.
- enable=0 while in RUN:
  - Next edge -> IDLE; the partial window is discarded (timer=0, acc=0).
  - alarm <= 0.
  - A pending report stays valid until accepted.
  - If enable falls in the close cycle, the close completes and the report loads; the FSM still goes to IDLE.
- running = (state==RUN), registered.
- rpt_ready is ignored when rpt_valid=0.

Optional Feature:
- Macro: DET_MON_GAP_EN.
- Defined:
  - Adds output rpt_min_gap [WIN_W]: the minimum distance in cycles between consecutive det_pulse events inside the reported window.
  - Back-to-back pulses have gap 1. Pulses in different windows are never paired.
  - If the window had fewer than 2 pulses, rpt_min_gap is all-ones.
  - rpt_min_gap loads, holds and overwrites under the same rules as rpt_count; reset value is all-ones.
  - Implementation: a gap counter and a min register, both cleared at window start.
- Undefined: the port and all gap logic are absent; all other behaviour is identical.

Test Plan:
1. WINDOW=16, THRESH=4, rpt_ready=1, enable=1; 3 pulses in window 0 -> one cycle after window close: rpt_valid=1, rpt_count=3, alarm=0; next cycle rpt_valid=0.
2. Pulses in cycle 15 of window 0 and cycle 0 of window 1 -> window 0 reports rpt_count=1 and window 1 counts its pulse as 1; with DET_MON_GAP_EN both windows report rpt_min_gap=all-ones.
3. rpt_ready=0 across two closes (counts 5, then 2) -> second report shows rpt_count=2, rpt_overrun=1, alarm=0; then rpt_ready=1 -> rpt_valid=0 and rpt_overrun=0.
4. CNT_W=3, det_pulse held high for a full 16-cycle window -> rpt_count=7 (saturated), alarm=1.
5. enable dropped at cycle 8 of a window with 2 pulses -> no report for that window, FSM in IDLE, running=0, alarm=0; re-enable -> fresh window starting with rpt_count=0.
6. Reset asserted asynchronously mid-window while rpt_valid=1 -> all outputs 0 immediately, with no clock edge needed; with DET_MON_GAP_EN, pulses at cycles 2, 5, 6 -> rpt_min_gap=1.
